alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the 16-bit single-cycle ALU.
- Keeps the same 3-bit opcode map.
- Width is generic.
- Replaces the combinational multiplier with an iterative shift-add multiplier.
- Adds a start/busy/done handshake and a full 2×WIDTH product output.
- Computes multiplication modulo 2^WIDTH+1 with the encoding "0 represents 2^WIDTH".
- Sits between the instruction decoder and the register-file write-back; the controller stalls on busy.

Parameters:
WIDTH, 16, operand/result width in bits (≥4).

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- opr  in  3  000 ADD, 001 PAS1, 010 SUB, 011 PAS2, 100 MLT, 101 AND, 110 OR, 111 XOR
- func  in  1  MLT mode: 0 full product, 1 modular product; ignored for other opr
- var1  in  WIDTH  operand A
- var2  in  WIDTH  operand B
- busy  out  1  high while a MLT is in progress
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  result (low word for MLT func=0)
- result_hi  out  WIDTH  high product word (MLT func=0), else 0
- sign  out  1  carry (ADD) / borrow (SUB), else 0
- zero  out  1  result == 0

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values:
  - Returns state to IDLE from any state, including mid-MLT; the partial product is discarded.
  - busy=0, done=0, result=0, result_hi=0, sign=0, zero=1.
- Operand capture:
  - start=1 in IDLE → opr, func, var1, var2 registered at that edge (call it edge 0).
  - start while busy is ignored; no queueing.
- Single-cycle ops (ADD, PAS1, SUB, PAS2, AND, OR, XOR):
  - Outputs registered at edge 0; done=1 in the following cycle (latency 1).
  - busy stays 0, so back-to-back start every cycle is legal.
  - ADD: {sign,result} = var1 + var2 in WIDTH+1 bits.
  - SUB: {sign,result} = {0,var1} − {0,var2}; sign=1 means borrow.
- State machine: IDLE → MUL → (MODR if func=1) → IDLE.
  - MUL:
    - One multiplier bit per cycle, LSB first, for exactly WIDTH cycles; busy=1.
    - Accumulator is 2×WIDTH wide, unsigned.
  - func=0:
    - Leaving MUL writes result=P[WIDTH-1:0], result_hi=P[2W-1:WIDTH].
    - done asserted WIDTH+1 cycles after edge 0.
  - MODR: one cycle, busy=1.
    - Let L=P[WIDTH-1:0], H=P[2W-1:WIDTH].
    - r = L−H if L≥H, else L−H+2^WIDTH+1, truncated to WIDTH bits.
    - Zero-operand override:
      - A=0 and B=0 → r=1.
      - A=0 only → r=(1−B) mod 2^WIDTH.
      - B=0 only → r=(1−A) mod 2^WIDTH.
    - A result equal to 2^WIDTH is output as 0.
    - result_hi=0; done asserted WIDTH+2 cycles after edge 0.
- busy deasserts in the same cycle done asserts; start may be accepted in that cycle.
- done is high for exactly one cycle per accepted start.
- result, result_hi, sign and zero hold until the next completion or reset.
- sign=0 and zero=(result==0) for all non-ADD/SUB ops.
- Inputs may change freely after the capture edge.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ADD..XOR);
  - state encoding (IDLE, MUL, MODR);
  - func constants (MLT_FULL=0, MLT_MOD=1).
- One sub-module, alu_mul_seq: the iterative shift-add multiplier.
  - Interface: load, operands, 2×WIDTH product, last-iteration flag.
- Modulo reduction and the simple ops stay in the top level.

Test Plan:
- ADD 0xFFFF+0x0001 (WIDTH=16) → done 1 cycle later, result=0x0000, sign=1, zero=1; SUB 0x0001−0x0002 → result=0xFFFF, sign=1, zero=0.
- MLT func=0, 0xFFFF×0xFFFF → busy 16 cycles; done at cycle 17; result=0x0001, result_hi=0xFFFE.
- MLT func=1:
  - 3×5 → 0x000F at cycle 18.
  - 0xFFFF×0xFFFF → 0x0004.
  - 0x0000×0x0002 → 0xFFFF.
  - 0x0000×0x0000 → 0x0001.
  - 0x0001×0x0000 → 0x0000.
- start pulsed with new operands during busy → ignored; original MLT result and single done pulse unchanged.
- reset asserted at cycle 8 of a MLT → next cycle busy=0, done=0, result=0, zero=1; a fresh ADD then completes normally.
- Back-to-back starts: AND, OR, XOR on consecutive cycles → three consecutive done pulses with correct results; repeat random ops against a reference model at WIDTH=8 and 32.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode map, controller states and multiply-mode constants shared by the
// sequential ALU and its multiplier.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_PAS1 = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_PAS2 = 3'b011;
  localparam logic [2:0] OP_MLT  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  localparam logic MLT_FULL = 1'b0;
  localparam logic MLT_MOD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_MODR = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock, LSB
// first, WIDTH iterations after load.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      count_reg;
  logic               running_reg;
  logic [WIDTH:0]     partial;

  // The low half of the accumulator starts as the multiplier and is shifted
  // out as product bits shift in from the top; product is the post-step value.
  assign partial = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
  assign product = {partial, acc_reg[WIDTH-1:1]};
  assign last    = running_reg && (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      running_reg <= 1'b0;
      count_reg   <= '0;
    end else if (load) begin
      mcand_reg   <= multiplicand;
      acc_reg     <= {{WIDTH{1'b0}}, multiplier};
      count_reg   <= '0;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      acc_reg   <= product;
      count_reg <= count_reg + 1'b1;
      if (last) begin
        running_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative full multiply and
// multiply modulo 2^WIDTH+1 (operand 0 stands for 2^WIDTH), start/busy/done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opr,
  input  logic             func,
  input  logic [WIDTH-1:0] var1,
  input  logic [WIDTH-1:0] var2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             sign,
  output logic             zero
);

  state_t state_reg, state_next;

  logic               func_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] prod_reg;

  logic               accept, mul_load, mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     simple_wide;
  logic [WIDTH-1:0]   lo_word, hi_word, mod_diff, mod_res;

  assign accept   = start && (state_reg == ST_IDLE);
  assign mul_load = accept && (opr == OP_MLT);
  assign busy     = (state_reg != ST_IDLE);

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock        (clock),
    .reset        (reset),
    .load         (mul_load),
    .multiplicand (var1),
    .multiplier   (var2),
    .product      (mul_product),
    .last         (mul_last)
  );

  // Top bit carries the ADD carry / SUB borrow and is 0 for every other op.
  always_comb begin
    simple_wide = '0;
    case (opr)
      OP_ADD:  simple_wide = {1'b0, var1} + {1'b0, var2};
      OP_SUB:  simple_wide = {1'b0, var1} - {1'b0, var2};
      OP_PAS1: simple_wide = {1'b0, var1};
      OP_PAS2: simple_wide = {1'b0, var2};
      OP_AND:  simple_wide = {1'b0, var1 & var2};
      OP_OR:   simple_wide = {1'b0, var1 | var2};
      OP_XOR:  simple_wide = {1'b0, var1 ^ var2};
      default: simple_wide = '0;
    endcase
  end

  // 2^W == -1 mod 2^W+1, so P == L-H; on wrap, +2^W+1 truncates to +1.
  assign lo_word  = prod_reg[WIDTH-1:0];
  assign hi_word  = prod_reg[2*WIDTH-1:WIDTH];
  assign mod_diff = lo_word - hi_word + {{(WIDTH-1){1'b0}}, (lo_word < hi_word)};

  always_comb begin
    mod_res = mod_diff;
    if ((a_reg == '0) && (b_reg == '0)) begin
      mod_res = WIDTH'(1);
    end else if (a_reg == '0) begin
      mod_res = WIDTH'(1) - b_reg;
    end else if (b_reg == '0) begin
      mod_res = WIDTH'(1) - a_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mul_load) state_next = ST_MUL;
      ST_MUL:  if (mul_last) state_next = (func_reg == MLT_MOD) ? ST_MODR : ST_IDLE;
      ST_MODR: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      sign      <= 1'b0;
      zero      <= 1'b1;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;

      if (accept) begin
        func_reg <= func;
        a_reg    <= var1;
        b_reg    <= var2;
        if (opr != OP_MLT) begin
          result    <= simple_wide[WIDTH-1:0];
          result_hi <= '0;
          sign      <= simple_wide[WIDTH];
          zero      <= (simple_wide[WIDTH-1:0] == '0);
          done      <= 1'b1;
        end
      end

      if ((state_reg == ST_MUL) && mul_last) begin
        if (func_reg == MLT_FULL) begin
          result    <= mul_product[WIDTH-1:0];
          result_hi <= mul_product[2*WIDTH-1:WIDTH];
          sign      <= 1'b0;
          zero      <= (mul_product[WIDTH-1:0] == '0);
          done      <= 1'b1;
        end else begin
          prod_reg <= mul_product;
        end
      end

      if (state_reg == ST_MODR) begin
        result    <= mod_res;
        result_hi <= '0;
        sign      <= 1'b0;
        zero      <= (mod_res == '0);
        done      <= 1'b1;
      end
    end
  end

endmodule
